// File: rtl/adder_result_stage.sv
// Registered result stage behind the carry-skip adder: overflow detect, optional
// saturation, overflow event counter, and a main+skid valid/ready buffer.
module adder_result_stage #(
  parameter int N        = 8,
  parameter bit SATURATE = 1'b0,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     a_i,
  input  logic [N-1:0]     b_i,
  input  logic [N-1:0]     sum_i,
  input  logic             cout_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [N-1:0]     result_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  input  logic             clr_cnt_i,
  output logic [CNT_W-1:0] ovf_cnt_o
);

  logic             main_vld_q, main_vld_d;
  logic [N-1:0]     main_res_q, main_res_d;
  logic             main_cout_q, main_cout_d;
  logic             main_ovf_q, main_ovf_d;
  logic             skid_vld_q, skid_vld_d;
  logic [N-1:0]     skid_res_q, skid_res_d;
  logic             skid_cout_q, skid_cout_d;
  logic             skid_ovf_q, skid_ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             in_ovf;
  logic [N-1:0]     in_res;
  logic             in_xfer;
  logic             drain;

  always_comb begin
    in_ovf = (a_i[N-1] == b_i[N-1]) && (sum_i[N-1] != a_i[N-1]);
    in_res = sum_i;
    if (SATURATE && in_ovf) begin
      in_res = a_i[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
  end

  // Ready depends only on skid occupancy, so no path from out_ready_i.
  assign in_ready_o = !skid_vld_q;
  assign in_xfer    = in_valid_i && !skid_vld_q;
  assign drain      = main_vld_q && out_ready_i;

  always_comb begin
    main_vld_d  = main_vld_q;
    main_res_d  = main_res_q;
    main_cout_d = main_cout_q;
    main_ovf_d  = main_ovf_q;
    skid_vld_d  = skid_vld_q;
    skid_res_d  = skid_res_q;
    skid_cout_d = skid_cout_q;
    skid_ovf_d  = skid_ovf_q;

    if (drain) begin
      if (skid_vld_q) begin
        main_res_d  = skid_res_q;
        main_cout_d = skid_cout_q;
        main_ovf_d  = skid_ovf_q;
        skid_vld_d  = 1'b0;
      end else begin
        main_vld_d = 1'b0;
      end
    end

    // in_xfer implies skid empty, so it never collides with the skid->main move.
    if (in_xfer) begin
      if (!main_vld_q || drain) begin
        main_vld_d  = 1'b1;
        main_res_d  = in_res;
        main_cout_d = cout_i;
        main_ovf_d  = in_ovf;
      end else begin
        skid_vld_d  = 1'b1;
        skid_res_d  = in_res;
        skid_cout_d = cout_i;
        skid_ovf_d  = in_ovf;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt_i) begin
      cnt_d = '0;
    end else if (in_xfer && in_ovf && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_vld_q  <= 1'b0;
      main_res_q  <= '0;
      main_cout_q <= 1'b0;
      main_ovf_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_res_q  <= '0;
      skid_cout_q <= 1'b0;
      skid_ovf_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      main_vld_q  <= main_vld_d;
      main_res_q  <= main_res_d;
      main_cout_q <= main_cout_d;
      main_ovf_q  <= main_ovf_d;
      skid_vld_q  <= skid_vld_d;
      skid_res_q  <= skid_res_d;
      skid_cout_q <= skid_cout_d;
      skid_ovf_q  <= skid_ovf_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid_o = main_vld_q;
  assign result_o    = main_res_q;
  assign cout_o      = main_cout_q;
  assign ovf_o       = main_ovf_q;
  assign ovf_cnt_o   = cnt_q;

endmodule

// File: tb/tb_adder_result_stage.sv
// Bench for adder_result_stage: three instances (wrap, saturate, 2-bit counter)
// share one stimulus stream and are compared against a FIFO-level model.
module tb_adder_result_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a = '0, b = '0, s = '0;
  logic       c = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       clr = 1'b0;

  logic [7:0]  res_w  [3];
  logic        cout_w [3];
  logic        ovf_w  [3];
  logic        vld_w  [3];
  logic        rdy_w  [3];
  logic [15:0] cnt_w  [3];
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  adder_result_stage #(.N(8), .SATURATE(1'b0), .CNT_W(16)) dut0 (
    .clk_i(clk), .rst_i(rst), .a_i(a), .b_i(b), .sum_i(s), .cout_i(c),
    .in_valid_i(in_valid), .in_ready_o(rdy_w[0]), .result_o(res_w[0]),
    .cout_o(cout_w[0]), .ovf_o(ovf_w[0]), .out_valid_o(vld_w[0]),
    .out_ready_i(out_ready), .clr_cnt_i(clr), .ovf_cnt_o(cnt0));
  adder_result_stage #(.N(8), .SATURATE(1'b1), .CNT_W(16)) dut1 (
    .clk_i(clk), .rst_i(rst), .a_i(a), .b_i(b), .sum_i(s), .cout_i(c),
    .in_valid_i(in_valid), .in_ready_o(rdy_w[1]), .result_o(res_w[1]),
    .cout_o(cout_w[1]), .ovf_o(ovf_w[1]), .out_valid_o(vld_w[1]),
    .out_ready_i(out_ready), .clr_cnt_i(clr), .ovf_cnt_o(cnt1));
  adder_result_stage #(.N(8), .SATURATE(1'b0), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .a_i(a), .b_i(b), .sum_i(s), .cout_i(c),
    .in_valid_i(in_valid), .in_ready_o(rdy_w[2]), .result_o(res_w[2]),
    .cout_o(cout_w[2]), .ovf_o(ovf_w[2]), .out_valid_o(vld_w[2]),
    .out_ready_i(out_ready), .clr_cnt_i(clr), .ovf_cnt_o(cnt2));

  assign cnt_w[0] = cnt0;
  assign cnt_w[1] = cnt1;
  assign cnt_w[2] = {14'b0, cnt2};

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- model: plain FIFO of raw adder transactions ----------------
  typedef struct packed { logic [7:0] a, b, s; logic c; } txn_t;
  txn_t q[$];
  int   mcnt [3];
  bit   fresh = 1'b1;
  bit   started = 1'b0;

  function automatic bit ovf_of(txn_t t);
    int sa, sb, ss;
    sa = $signed(t.a);
    sb = $signed(t.b);
    ss = sa + sb;
    return (ss > 127) || (ss < -128);
  endfunction

  function automatic logic [7:0] res_of(txn_t t, bit sat);
    if (sat && ovf_of(t)) return t.a[7] ? 8'h80 : 8'h7F;
    return t.s;
  endfunction

  function automatic int cmax(int i);
    return (i == 2) ? 3 : 65535;
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) mcnt[i] = 0;
    forever begin
      @(posedge clk);
      started = 1'b1;
      if (rst) begin
        q.delete();
        for (int i = 0; i < 3; i++) mcnt[i] = 0;
        fresh = 1'b1;
      end else begin
        bit   pop, push;
        txn_t t;
        t    = '{a: a, b: b, s: s, c: c};
        pop  = (q.size() > 0) && out_ready;
        push = in_valid && (q.size() < 2);
        for (int i = 0; i < 3; i++) begin
          if (clr) mcnt[i] = 0;
          else if (push && ovf_of(t) && mcnt[i] < cmax(i)) mcnt[i]++;
        end
        if (pop) void'(q.pop_front());
        if (push) begin
          q.push_back(t);
          fresh = 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("in_ready[%0d]", i), 32'(rdy_w[i]), 32'(q.size() < 2));
        chk($sformatf("out_valid[%0d]", i), 32'(vld_w[i]), 32'(q.size() > 0));
        chk($sformatf("ovf_cnt[%0d]", i), 32'(cnt_w[i]), 32'(mcnt[i]));
        if (q.size() > 0) begin
          chk($sformatf("result[%0d]", i), 32'(res_w[i]), 32'(res_of(q[0], i == 1)));
          chk($sformatf("cout[%0d]", i), 32'(cout_w[i]), 32'(q[0].c));
          chk($sformatf("ovf[%0d]", i), 32'(ovf_w[i]), 32'(ovf_of(q[0])));
        end else if (fresh) begin
          chk($sformatf("rst_result[%0d]", i), 32'(res_w[i]), 32'h0);
          chk($sformatf("rst_flags[%0d]", i), 32'({cout_w[i], ovf_w[i]}), 32'h0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] ta, input logic [7:0] tb_, input logic [7:0] ts, input logic tc);
    bit acc;
    a = ta; b = tb_; s = ts; c = tc; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      acc = (q.size() < 2) && !rst;
      @(negedge clk);
      if (acc) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL send_timeout: got no accept, expected accept within 50 cycles");
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset(3);
    chk("reset_valid", 32'(vld_w[0]), 32'h0);
    chk("reset_cnt", 32'(cnt_w[0]), 32'h0);

    // Wrap vs saturate on the same stream
    send(8'h7F, 8'h01, 8'h80, 1'b0);
    chk("lit_wrap_res", 32'(res_w[0]), 32'h80);
    chk("lit_wrap_ovf", 32'(ovf_w[0]), 32'h1);
    chk("lit_wrap_cnt", 32'(cnt_w[0]), 32'h1);
    chk("lit_sat_pos", 32'(res_w[1]), 32'h7F);
    send(8'h80, 8'hFF, 8'h7F, 1'b1);
    chk("lit_sat_neg", 32'(res_w[1]), 32'h80);
    chk("lit_sat_neg_cout", 32'(cout_w[1]), 32'h1);
    chk("lit_wrap_neg", 32'(res_w[0]), 32'h7F);
    send(8'h05, 8'hFE, 8'h03, 1'b1);
    chk("lit_noovf_res", 32'(res_w[1]), 32'h03);
    chk("lit_noovf_ovf", 32'(ovf_w[1]), 32'h0);
    chk("lit_cnt_hold", 32'(cnt_w[0]), 32'h2);
    idle();
    repeat (2) @(negedge clk);

    // Backpressure: two accepted, third held, then drain without gaps
    out_ready = 1'b0;
    send(8'h01, 8'h00, 8'h01, 1'b0);
    send(8'h02, 8'h00, 8'h02, 1'b0);
    a = 8'h03; b = 8'h00; s = 8'h03; c = 1'b0;
    chk("lit_bp_ready", 32'(rdy_w[0]), 32'h0);
    repeat (2) @(negedge clk);
    chk("lit_bp_hold", 32'(res_w[0]), 32'h01);
    chk("lit_bp_ready2", 32'(rdy_w[0]), 32'h0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("lit_bp_2", 32'(res_w[0]), 32'h02);
    @(negedge clk);
    chk("lit_bp_3", 32'(res_w[0]), 32'h03);
    idle();
    @(negedge clk);
    chk("lit_bp_empty", 32'(vld_w[0]), 32'h0);

    // Saturating 2-bit counter and clear priority
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      send(8'h7F, 8'h01, 8'h80, 1'b0);
      chk("lit_cnt2", 32'(cnt_w[2]), (i < 3) ? 32'(i + 1) : 32'h3);
    end
    clr = 1'b1;
    send(8'h40, 8'h40, 8'h80, 1'b0);
    clr = 1'b0;
    chk("lit_clr_cnt2", 32'(cnt_w[2]), 32'h0);
    chk("lit_clr_cnt0", 32'(cnt_w[0]), 32'h0);
    idle();
    repeat (2) @(negedge clk);

    // Reset with main+skid full
    out_ready = 1'b0;
    send(8'h7F, 8'h01, 8'h80, 1'b0);
    send(8'h7F, 8'h02, 8'h81, 1'b0);
    idle();
    do_reset(1);
    chk("lit_rst_valid", 32'(vld_w[0]), 32'h0);
    chk("lit_rst_cnt", 32'(cnt_w[0]), 32'h0);
    chk("lit_rst_ready", 32'(rdy_w[0]), 32'h1);
    out_ready = 1'b1;
    send(8'h11, 8'h22, 8'h33, 1'b0);
    idle();
    chk("lit_post_rst", 32'(res_w[0]), 32'h33);
    @(negedge clk);
    chk("lit_post_rst_alone", 32'(vld_w[0]), 32'h0);

    // Random valid/ready traffic
    begin
      int sent = 0;
      int cyc = 0;
      while (sent < 10000 && cyc < 60000) begin
        bit acc;
        if (!in_valid && $urandom_range(0, 9) < 7) begin
          logic [8:0] full;
          a = 8'($urandom);
          b = 8'($urandom);
          full = {1'b0, a} + {1'b0, b};
          s = full[7:0];
          c = full[8];
          in_valid = 1'b1;
        end
        out_ready = ($urandom_range(0, 9) < 6);
        clr = ($urandom_range(0, 99) == 0);
        acc = in_valid && (q.size() < 2);
        @(negedge clk);
        cyc++;
        if (acc) begin
          sent++;
          in_valid = 1'b0;
        end
      end
      if (sent < 10000) begin
        vectors++;
        miscompares++;
        $display("FAIL random_budget: got %0d accepts, expected 10000", sent);
      end
    end
    idle();
    clr = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("final_drained", 32'(vld_w[0]), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adder_result_stage.md
Name: adder_result_stage

Overview:
- Registered output stage that sits directly downstream of the N-bit carry-skip adder.
- Captures the adder's operands, sum and carry-out, and computes the two's-complement overflow flag.
- Optionally saturates the signed result and counts overflow events.
- Decouples the combinational adder from its consumer with a valid/ready interface and a 2-entry skid buffer, sustaining one result per cycle.

Parameters:
- N, 8, operand/result width in bits; must match the adder.
- SATURATE, 0, 1 = replace an overflowed result with the signed max/min; 0 = pass the wrapped sum through.
- CNT_W, 16, width of the overflow event counter.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- a_i  input  N  operand A as presented to the adder.
- b_i  input  N  operand B as presented to the adder.
- sum_i  input  N  adder sum_o.
- cout_i  input  1  adder cout_o.
- in_valid_i  input  1  a_i/b_i/sum_i/cout_i are valid this cycle.
- in_ready_o  output  1  stage can accept an input this cycle.
- result_o  output  N  registered (optionally saturated) signed result.
- cout_o  output  1  registered unsigned carry-out.
- ovf_o  output  1  registered signed-overflow flag for result_o.
- out_valid_o  output  1  result_o/cout_o/ovf_o hold a valid entry.
- out_ready_i  input  1  consumer accepts the output this cycle.
- clr_cnt_i  input  1  synchronous clear of the overflow counter.
- ovf_cnt_o  output  CNT_W  number of accepted inputs that overflowed; saturates at all-ones.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high (clk_i, rst_i).
  - While rst_i=1: out_valid_o=0, result_o=0, cout_o=0, ovf_o=0, ovf_cnt_o=0, skid entry empty.
  - Inputs presented while rst_i=1 are discarded.
  - Reset mid-operation drops all buffered entries; nothing is replayed.
- Transfers:
  - Input transfer: in_valid_i & in_ready_o on a rising edge with rst_i=0.
  - Output transfer: out_valid_o & out_ready_i.
- Overflow and result computation (applied to the input at capture time):
  - ovf = (a_i[N-1] == b_i[N-1]) & (sum_i[N-1] != a_i[N-1]).
  - Result with SATURATE=0: sum_i.
  - Result with SATURATE=1 and ovf=1: a_i[N-1]=0 gives 0 followed by N-1 ones (max positive); a_i[N-1]=1 gives 1 followed by N-1 zeros (min negative).
  - cout_o is always the captured cout_i, never saturated.
- Buffer: main register drives the outputs, plus one skid register.
  - in_ready_o = NOT skid_full. It is a registered-state function only, with no combinational path from out_ready_i.
  - Latency: accepted input appears on outputs the next cycle when main is empty or draining.
  - Main empty, or main draining this cycle: input loads main.
  - Main full and not draining: input loads skid; in_ready_o drops the next cycle.
  - Main drains with skid full: skid moves to main and skid empties. No input is accepted in that cycle because in_ready_o=0.
  - Order is strictly FIFO. No entry is dropped or duplicated under any valid/ready pattern.
  - Output stability: while out_valid_o=1 and out_ready_i=0, result_o/cout_o/ovf_o/out_valid_o hold.
- Counter:
  - Increments by 1 on each input transfer with ovf=1.
  - Holds at 2^CNT_W-1.
  - clr_cnt_i=1 sets it to 0 next cycle. Clear has priority over a simultaneous increment, so the result is 0.
- Throughput: 1 result/cycle with out_ready_i held high.

Test Plan:
- N=8, SATURATE=0: a=0x7F, b=0x01, sum=0x80, cout=0, out_ready=1 -> next cycle result=0x80, ovf=1, cout=0, ovf_cnt=1.
- SATURATE=1: a=0x7F, b=0x01, sum=0x80 -> result=0x7F, ovf=1. Then a=0x80, b=0xFF, sum=0x7F, cout=1 -> result=0x80, ovf=1, cout=1. Then a=0x05, b=0xFE, sum=0x03, cout=1 -> result=0x03, ovf=0.
- Backpressure: out_ready=0 and send 0x01, 0x02, 0x03 back-to-back -> first two accepted, in_ready=0 from cycle 2, 0x03 held by source. Raise out_ready -> outputs 0x01, 0x02, 0x03 in order on consecutive cycles, no gaps once draining.
- Random valid/ready, 10k transactions -> scoreboard matches in order; outputs stable under stall; out_valid never asserts without a prior accept.
- CNT_W=2: 5 overflowing inputs -> ovf_cnt 1, 2, 3, 3, 3. clr_cnt_i on the same cycle as an overflowing accept -> ovf_cnt=0.
- Fill main+skid, assert rst_i for 1 cycle -> out_valid=0, ovf_cnt=0, in_ready=1 after reset. Next input appears alone, with no stale entries.
